// File: rtl/debouncer.sv
// Two-flop synchronizer followed by a counter-based debounce FSM; a new level is accepted only
// after DEBOUNCE_CYCLES consecutive mismatching samples. Define DEBOUNCE_PULSE_EN for edge pulses.
module debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter logic        RESET_VALUE     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_raw,
  output logic a_clean,
  output logic busy,
  output logic rise_p,
  output logic fall_p
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {StStable, StCounting} state_e;

  state_e        state_q;
  logic          s1_q;
  logic          s2_q;
  logic [CW-1:0] cnt_q;
  logic          accept;

  // A single-cycle debounce accepts straight from STABLE without ever counting.
  always_comb begin
    accept = 1'b0;
    if (s2_q != a_clean) begin
      unique case (state_q)
        StStable:   accept = (DEBOUNCE_CYCLES == 1);
        StCounting: accept = (cnt_q == CntMax);
        default:    accept = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= RESET_VALUE;
      s2_q    <= RESET_VALUE;
      a_clean <= RESET_VALUE;
      cnt_q   <= '0;
      state_q <= StStable;
      busy    <= 1'b0;
    end else begin
      s1_q <= a_raw;
      s2_q <= s1_q;
      if (accept) begin
        a_clean <= s2_q;
        cnt_q   <= '0;
        state_q <= StStable;
        busy    <= 1'b0;
      end else begin
        unique case (state_q)
          StStable: begin
            if (s2_q != a_clean) begin
              cnt_q   <= CW'(1);
              state_q <= StCounting;
              busy    <= 1'b1;
            end
          end
          StCounting: begin
            if (s2_q == a_clean) begin
              cnt_q   <= '0;
              state_q <= StStable;
              busy    <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: begin
            cnt_q   <= '0;
            state_q <= StStable;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef DEBOUNCE_PULSE_EN
  // Pulses are registered alongside a_clean so they line up with the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_p <= 1'b0;
      fall_p <= 1'b0;
    end else begin
      rise_p <= accept & s2_q;
      fall_p <= accept & ~s2_q;
    end
  end
`else
  assign rise_p = 1'b0;
  assign fall_p = 1'b0;
`endif

endmodule

// File: tb/tb_debouncer.sv
// Self-checking bench: two debouncers (4-cycle and 1-cycle) share one stimulus and are compared
// every cycle against a run-length reference model.
module tb_debouncer;

  logic clk;
  logic rst_n;
  logic a_raw;
  logic a_clean_w [2];
  logic busy_w    [2];
  logic rise_w    [2];
  logic fall_w    [2];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: synchronizer as a 2-deep history, debounce as a mismatch run length.
  int unsigned dc [2] = '{4, 1};
  logic m_s1 [2];
  logic m_s2 [2];
  logic m_clean [2];
  int unsigned m_run [2];
  logic m_busy [2];
  logic m_rise [2];
  logic m_fall [2];

  debouncer #(.DEBOUNCE_CYCLES(4), .RESET_VALUE(1'b0)) dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_raw   (a_raw),
    .a_clean (a_clean_w[0]),
    .busy    (busy_w[0]),
    .rise_p  (rise_w[0]),
    .fall_p  (fall_w[0])
  );

  debouncer #(.DEBOUNCE_CYCLES(1), .RESET_VALUE(1'b0)) dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_raw   (a_raw),
    .a_clean (a_clean_w[1]),
    .busy    (busy_w[1]),
    .rise_p  (rise_w[1]),
    .fall_p  (fall_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = 1'b0;
      m_s2[i] = 1'b0;
      m_clean[i] = 1'b0;
      m_run[i] = 0;
      m_busy[i] = 1'b0;
      m_rise[i] = 1'b0;
      m_fall[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      m_rise[i] = 1'b0;
      m_fall[i] = 1'b0;
      if (m_s2[i] != m_clean[i]) begin
        m_run[i]++;
        if (m_run[i] == dc[i]) begin
          m_clean[i] = m_s2[i];
          m_rise[i] = m_s2[i];
          m_fall[i] = ~m_s2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      m_busy[i] = (m_run[i] != 0);
      m_s2[i] = m_s1[i];
      m_s1[i] = a_raw;
    end
  endtask

  task automatic check_all(input string tag);
    logic er;
    logic ef;
    for (int i = 0; i < 2; i++) begin
`ifdef DEBOUNCE_PULSE_EN
      er = m_rise[i];
      ef = m_fall[i];
`else
      er = 1'b0;
      ef = 1'b0;
`endif
      chk($sformatf("%s a_clean[D=%0d]", tag, dc[i]), a_clean_w[i], m_clean[i]);
      chk($sformatf("%s busy[D=%0d]", tag, dc[i]), busy_w[i], m_busy[i]);
      chk($sformatf("%s rise_p[D=%0d]", tag, dc[i]), rise_w[i], er);
      chk($sformatf("%s fall_p[D=%0d]", tag, dc[i]), fall_w[i], ef);
      chk($sformatf("%s excl[D=%0d]", tag, dc[i]), rise_w[i] & fall_w[i], 1'b0);
    end
  endtask

  task automatic step(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
      check_all(tag);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_raw = 1'b1;
    model_reset();
    #1;
    check_all("reset");
    step(3, "in_reset");

    // Release with a_raw held high: a_clean rises 6 edges later.
    rst_n = 1'b1;
    step(5, "release");
    chk("latency_before", a_clean_w[0], 1'b0);
    step(1, "release");
    chk("latency_at", a_clean_w[0], 1'b1);
    step(3, "release_hold");

    // Clean fall then clean rise.
    a_raw = 1'b0;
    step(8, "clean_fall");
    a_raw = 1'b1;
    step(8, "clean_rise");
    a_raw = 1'b0;
    step(8, "settle_low");

    // Glitch of three cycles.
    a_raw = 1'b1;
    step(3, "glitch");
    a_raw = 1'b0;
    step(8, "glitch_after");

    // Bounce 1,0,1,0 then hold high.
    for (int b = 0; b < 2; b++) begin
      a_raw = 1'b1;
      step(1, "bounce");
      a_raw = 1'b0;
      step(1, "bounce");
    end
    a_raw = 1'b1;
    step(10, "bounce_hold");

    // Falling edge cut short by an asynchronous reset.
    a_raw = 1'b0;
    step(3, "fall_pending");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("mid_reset");
    chk("mid_reset_clean", a_clean_w[0], 1'b0);
    step(2, "mid_reset_hold");
    rst_n = 1'b1;
    step(6, "post_reset");

    // Full fall without reset.
    a_raw = 1'b1;
    step(8, "rise_again");
    a_raw = 1'b0;
    step(8, "fall_full");

    // Single-cycle debounce boundary: accepted 3 edges after first sample.
    a_raw = 1'b1;
    step(2, "d1_boundary");
    chk("d1_before", a_clean_w[1], 1'b0);
    a_raw = 1'b0;
    step(1, "d1_boundary");
    chk("d1_at", a_clean_w[1], 1'b1);
    step(6, "d1_after");

    // Random runs of varied length to exercise bounces and accepts.
    for (int r = 0; r < 60; r++) begin
      a_raw = 1'($urandom_range(0, 1));
      step(int'($urandom_range(1, 7)), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
